sram_mem_stage: RTL

- Memory-stage controller directly downstream of the execute stage.
- Consumes the ALU result as the byte address and the forwarded Rm value as store data.
- Performs 32-bit loads and stores on an external 16-bit SRAM as two half-word accesses.
- Deasserts ready to freeze the pipeline while an access is in progress.

---
 rtl/sram_mem_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sram_mem_stage.sv
// sram_mem_stage: memory-stage controller that performs 32-bit loads/stores as two 16-bit SRAM half accesses.
// Latency: ready low for 1 + 2*PHASE_CYCLES cycles per access (a cache hit completes in the request cycle).
// Backpressure: ready drops while an access is in flight, freezing the upstream pipeline with its request held.
// Ports: clk/rst; mem_read, mem_write, address, write_data in; read_data, ready out;
//        SRAM side: sram_addr, sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n, sram_oe_n.
// Optional: define SRAM_LAST_WORD_CACHE_EN for a one-entry write-through, write-allocate last-word cache.
module sram_mem_stage #(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

    localparam int             PW         = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PW-1:0]  PHASE_LAST = PW'(PHASE_CYCLES - 1);

    state_t        state;
    logic [PW-1:0] phase;
    logic [31:0]   read_data_q;
    logic [31:0]   word;
    logic [17:0]   addr_lo;
    logic [17:0]   addr_hi;
    logic          phase_end;
    logic          hit;
    logic [31:0]   hit_dat;
    logic          unused_word_bits;

    // Modulo-2^32 offset: addresses below ADDR_BASE wrap to the top of the SRAM.
    assign word      = (address - ADDR_BASE) >> 2;
    assign addr_lo   = {word[16:0], 1'b0};
    assign addr_hi   = {word[16:0], 1'b1};
    assign phase_end = (phase == PHASE_LAST);
    assign unused_word_bits = ^word[31:17];

`ifdef SRAM_LAST_WORD_CACHE_EN
    logic        c_vld;
    logic [31:0] c_tag;
    logic [31:0] c_dat;

    // mem_write wins over mem_read, so a combined request is never a hit.
    assign hit     = (state == IDLE) && mem_read && !mem_write && c_vld && (c_tag == word);
    assign hit_dat = c_dat;

    // Entry is refreshed on the edge that enters DONE, from either direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_vld <= 1'b0;
        end else if (phase_end && (state == WR_HI)) begin
            c_vld <= 1'b1;
            c_tag <= word;
            c_dat <= write_data;
        end else if (phase_end && (state == RD_HI)) begin
            c_vld <= 1'b1;
            c_tag <= word;
            c_dat <= {sram_dq_in, read_data_q[15:0]};
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_dat = 32'h0;
`endif

    assign read_data = hit ? hit_dat : read_data_q;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = hit || !(mem_read || mem_write);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // SRAM pins are registered: each transition loads the values for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            read_data_q <= 32'h0;
            sram_addr   <= 18'h0;
            sram_dq_out <= 16'h0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (mem_write) begin
                        state       <= WR_LO;
                        sram_addr   <= addr_lo;
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= 1'b0;
                        sram_oe_n   <= 1'b1;
                    end else if (hit) begin
                        read_data_q <= hit_dat;
                    end else if (mem_read) begin
                        state     <= RD_LO;
                        sram_addr <= addr_lo;
                        sram_oe_n <= 1'b0;
                    end
                end
                WR_LO: begin
                    if (phase_end) begin
                        state       <= WR_HI;
                        phase       <= '0;
                        sram_addr   <= addr_hi;
                        sram_dq_out <= write_data[31:16];
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                WR_HI: begin
                    if (phase_end) begin
                        state      <= DONE;
                        phase      <= '0;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                RD_LO: begin
                    if (phase_end) begin
                        state             <= RD_HI;
                        phase             <= '0;
                        read_data_q[15:0] <= sram_dq_in;
                        sram_addr         <= addr_hi;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                RD_HI: begin
                    if (phase_end) begin
                        state              <= DONE;
                        phase              <= '0;
                        read_data_q[31:16] <= sram_dq_in;
                        sram_oe_n          <= 1'b1;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    phase <= '0;
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule
